// File: rtl/lvds_pwm_rx_if.sv
// Pin/result bundle for the HSMC differential PWM receiver.
// The master side drives the lane wires; the slave (receiver) reports decoded results.
interface lvds_pwm_rx_if;
  logic [3:0] HSMC_RX_p;
  logic [3:0] HSMC_RX_n;
  logic [3:0] duty_code;
  logic [3:0] lane_mask;
  logic       valid;
  logic       locked;
  logic       err;

  modport master (
    output HSMC_RX_p, HSMC_RX_n,
    input  duty_code, lane_mask, valid, locked, err
  );

  modport slave (
    input  HSMC_RX_p, HSMC_RX_n,
    output duty_code, lane_mask, valid, locked, err
  );
endinterface

// File: rtl/lvds_pwm_rx.sv
// Receive side of the HSMC differential PWM link: locks to the fixed frame period and
// recovers the 4-bit duty code and active-lane mask from the p-phase length.
module lvds_pwm_rx #(
  parameter int PERIOD = 1087,
  parameter int TOL    = 8,
  parameter int CNT_W  = 12
) (
  input logic          OSC_50_B8A,
  input logic          RESET,
  lvds_pwm_rx_if.slave rx
);

  localparam int ACC_W = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] PER_LO  = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] PER_HI  = CNT_W'(PERIOD + TOL);
  localparam logic [CNT_W-1:0] PER_TO  = CNT_W'(2 * PERIOD);
  localparam logic [ACC_W-1:0] ACC_INI = ACC_W'(PERIOD);
  localparam logic [ACC_W-1:0] ACC_STP = ACC_W'(2 * PERIOD);

  typedef enum logic [1:0] {IDLE, MEAS, DECODE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       p_s1_q, p_s_q, n_s1_q, n_s_q;
  logic             p_any_q;
  logic [CNT_W-1:0] per_q, per_d, hi_q, hi_d;
  logic [3:0]       act_q, act_d;
  logic             ovl_q, ovl_d;
  logic             pend_q, pend_d;
  logic [3:0]       k_q, k_d;
  logic [ACC_W-1:0] acc_q, acc_d, hs_q, hs_d;
  logic [3:0]       a_q, a_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       duty_q, duty_d, mask_q, mask_d;
  logic             valid_q, valid_d, locked_q, locked_d, err_q, err_d;

  logic             p_any, n_any, rise, overlap;
  logic [3:0]       lanes, code_step;
  logic [CNT_W-1:0] per_inc, hi_inc;

  assign p_any   = |p_s_q;
  assign n_any   = |n_s_q;
  assign rise    = p_any & ~p_any_q;
  assign overlap = p_any & n_any;
  assign lanes   = p_s_q | n_s_q;
  assign per_inc = (per_q == CNT_MAX) ? per_q : per_q + CNT_W'(1);
  assign hi_inc  = (hi_q == CNT_MAX || !p_any) ? hi_q : hi_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    per_d     = per_q;
    hi_d      = hi_q;
    act_d     = act_q;
    ovl_d     = ovl_q;
    pend_d    = pend_q;
    k_d       = k_q;
    acc_d     = acc_q;
    hs_d      = hs_q;
    a_d       = a_q;
    code_d    = code_q;
    code_step = code_q;
    duty_d    = duty_q;
    mask_d    = mask_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    locked_d  = locked_q;

    case (state_q)
      IDLE: begin
        if (rise) begin
          per_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
          act_d   = lanes;
          ovl_d   = overlap;
          state_d = MEAS;
        end
      end

      MEAS: begin
        per_d  = per_inc;
        hi_d   = hi_inc;
        act_d  = act_q | lanes;
        ovl_d  = ovl_q | overlap;
        pend_d = 1'b0;
        if (rise || pend_q) begin
          per_d = CNT_W'(1);
          hi_d  = CNT_W'(1);
          act_d = lanes;
          ovl_d = overlap;
          if (ovl_q || per_q < PER_LO || per_q > PER_HI) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end else begin
            // 32*(H-1) is compared against odd multiples of PERIOD, i.e. half-step thresholds
            hs_d    = (hi_q == '0) ? '0 : {hi_q - CNT_W'(1), 5'b0};
            a_d     = act_q;
            acc_d   = ACC_INI;
            k_d     = 4'd1;
            code_d  = 4'd0;
            state_d = DECODE;
          end
        end else if (per_q >= PER_TO) begin
          err_d    = 1'b1;
          locked_d = 1'b0;
          state_d  = IDLE;
        end
      end

      DECODE: begin
        per_d = per_inc;
        hi_d  = hi_inc;
        act_d = act_q | lanes;
        ovl_d = ovl_q | overlap;
        if (rise) pend_d = 1'b1;
        if (hs_q >= acc_q && code_q != 4'd15) code_step = code_q + 4'd1;
        acc_d  = acc_q + ACC_STP;
        k_d    = k_q + 4'd1;
        code_d = code_step;
        if (k_q == 4'd15) begin
          duty_d   = code_step;
          mask_d   = a_q;
          valid_d  = 1'b1;
          locked_d = 1'b1;
          state_d  = MEAS;
        end
      end

      default: state_d = IDLE;
    endcase

    if (err_d) valid_d = 1'b0;
  end

  always_ff @(posedge OSC_50_B8A or posedge RESET) begin
    if (RESET) begin
      p_s1_q   <= '0;
      p_s_q    <= '0;
      n_s1_q   <= '0;
      n_s_q    <= '0;
      p_any_q  <= 1'b0;
      state_q  <= IDLE;
      per_q    <= '0;
      hi_q     <= '0;
      act_q    <= '0;
      ovl_q    <= 1'b0;
      pend_q   <= 1'b0;
      k_q      <= '0;
      acc_q    <= '0;
      hs_q     <= '0;
      a_q      <= '0;
      code_q   <= '0;
      duty_q   <= '0;
      mask_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      p_s1_q   <= rx.HSMC_RX_p;
      p_s_q    <= p_s1_q;
      n_s1_q   <= rx.HSMC_RX_n;
      n_s_q    <= n_s1_q;
      p_any_q  <= p_any;
      state_q  <= state_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      act_q    <= act_d;
      ovl_q    <= ovl_d;
      pend_q   <= pend_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      hs_q     <= hs_d;
      a_q      <= a_d;
      code_q   <= code_d;
      duty_q   <= duty_d;
      mask_q   <= mask_d;
      valid_q  <= valid_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign rx.duty_code = duty_q;
  assign rx.lane_mask = mask_q;
  assign rx.valid     = valid_q;
  assign rx.locked    = locked_q;
  assign rx.err       = err_q;

endmodule

// File: tb/tb_lvds_pwm_rx.sv
// Scoreboard bench for lvds_pwm_rx: a TX model drives PWM frames and every valid pulse
// is matched against the expected code/mask queued when that frame was sent.
module tb_lvds_pwm_rx;
  localparam int PERIOD = 1087;

  typedef struct {
    logic [3:0] code;
    logic [3:0] mask;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  lvds_pwm_rx_if bus ();

  lvds_pwm_rx #(.PERIOD(PERIOD), .TOL(8), .CNT_W(12)) dut (
    .OSC_50_B8A (clk),
    .RESET      (rst),
    .rx         (bus)
  );

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   err_cnt     = 0;
  int   err_cyc     = 0;
  int   frame_start = 0;

  // Reference decode: largest k with 32*(H-1) >= (2k-1)*PERIOD, clamped to 15
  function automatic int exp_code(input int hi);
    int c;
    if (hi <= 0) return 0;
    c = (32 * (hi - 1) + PERIOD) / (2 * PERIOD);
    return (c > 15) ? 15 : c;
  endfunction

  // p-high length centred on code c's decision window
  function automatic int hi_for(input int c);
    return 1 + (c * 2 * PERIOD) / 32;
  endfunction

  task automatic push(input int code, input logic [3:0] mask);
    exp_t e;
    e.code = 4'(code);
    e.mask = mask;
    sb.push_back(e);
  endtask

  // One clock of the TX model: sample DUT outputs on the falling edge, then drive pins.
  task automatic tick(input logic [3:0] p, input logic [3:0] n, input bit mark);
    exp_t e;
    int   lat;
    @(negedge clk);
    if (bus.valid === 1'b1) begin
      $display("[%0d] valid duty_code=%0d lane_mask=%h", cyc, bus.duty_code, bus.lane_mask);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got duty=%0d mask=%h, required no valid", bus.duty_code, bus.lane_mask);
      end else begin
        e = sb.pop_front();
        if ({bus.duty_code, bus.lane_mask} !== {e.code, e.mask}) begin
          miscompares++;
          $display("FAIL decode: got duty=%0d mask=%h, required duty=%0d mask=%h",
                   bus.duty_code, bus.lane_mask, e.code, e.mask);
        end
        vectors++;
        lat = cyc - frame_start;
        if (lat < 17 || lat > 20) begin
          miscompares++;
          $display("FAIL valid_latency: got %0d cycles after frame start, required 17..20", lat);
        end
      end
    end
    if (bus.err === 1'b1) begin
      $display("[%0d] err pulse", cyc);
      err_cnt++;
      err_cyc = cyc;
    end
    if (mark) frame_start = cyc;
    bus.HSMC_RX_p = p;
    bus.HSMC_RX_n = n;
  endtask

  task automatic frame(input logic [3:0] d, input int hi, input int len, input int ovl_at);
    logic [3:0] p, n;
    for (int i = 0; i < len; i++) begin
      p = (i < hi) ? d : 4'h0;
      n = (i < hi) ? 4'h0 : d;
      if (i == ovl_at) begin
        p = 4'h1;
        n = 4'h1;
      end
      tick(p, n, i == 0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick(4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic check_quiet(input string name, input int err0);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_missing_valid: got %0d pending, required 0", name, sb.size());
    end
    vectors++;
    if (err_cnt - err0 != 0) begin
      miscompares++;
      $display("FAIL %s_err: got %0d err pulses, required 0", name, err_cnt - err0);
    end
  endtask

  task automatic test_reset();
    repeat (4) tick(4'hF, 4'h0, 1'b0);
    vectors++;
    if (bus.duty_code !== 4'h0) begin miscompares++; $display("FAIL reset_duty: got %h, required 0", bus.duty_code); end
    vectors++;
    if (bus.lane_mask !== 4'h0) begin miscompares++; $display("FAIL reset_mask: got %h, required 0", bus.lane_mask); end
    vectors++;
    if (bus.valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b, required 0", bus.valid); end
    vectors++;
    if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked: got %b, required 0", bus.locked); end
    vectors++;
    if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b, required 0", bus.err); end
  endtask

  task automatic test_basic();
    int err0;
    do_reset();
    err0 = err_cnt;
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    frame(4'hF, 340, PERIOD, -1); push(exp_code(340), 4'hF);
    frame(4'hF, 340, PERIOD, -1);
    check_quiet("basic", err0);
    vectors++;
    if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL basic_locked: got %b, required 1", bus.locked); end
    vectors++;
    if (bus.duty_code !== 4'd5) begin miscompares++; $display("FAIL basic_duty: got %0d, required 5", bus.duty_code); end
    vectors++;
    if (bus.lane_mask !== 4'hF) begin miscompares++; $display("FAIL basic_mask: got %h, required f", bus.lane_mask); end
  endtask

  task automatic test_code_sweep();
    int err0;
    do_reset();
    err0 = err_cnt;
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    for (int c = 0; c < 16; c++) begin
      frame(4'hF, hi_for(c), PERIOD, -1);
      push(c, 4'hF);
    end
    frame(4'hF, 340, PERIOD, -1);
    check_quiet("sweep", err0);
  endtask

  task automatic test_lane_mask();
    int err0;
    do_reset();
    err0 = err_cnt;
    frame(4'h5, hi_for(9), PERIOD, -1); push(9, 4'h5);
    frame(4'hA, hi_for(3), PERIOD, -1); push(3, 4'hA);
    frame(4'hF, 340, PERIOD, -1);
    check_quiet("mask", err0);
    vectors++;
    if (bus.lane_mask !== 4'hA) begin miscompares++; $display("FAIL mask_hold: got %h, required a", bus.lane_mask); end
  endtask

  task automatic test_period_err();
    int err0;
    do_reset();
    err0 = err_cnt;
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    frame(4'hF, 340, 1200, -1);
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    vectors++;
    if (err_cnt - err0 != 1) begin miscompares++; $display("FAIL period_err: got %0d err pulses, required 1", err_cnt - err0); end
    vectors++;
    if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL period_unlock: got %b, required 0", bus.locked); end
    frame(4'hF, 340, PERIOD, -1);
    check_quiet("period_relock", err0 + 1);
    vectors++;
    if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL period_relock_locked: got %b, required 1", bus.locked); end
  endtask

  task automatic test_overlap_timeout();
    int  err0, err1, t0, lat;
    bool_loop: begin end
    do_reset();
    err0 = err_cnt;
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    frame(4'hF, 340, PERIOD, 170);
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    vectors++;
    if (err_cnt - err0 != 1) begin miscompares++; $display("FAIL overlap_err: got %0d err pulses, required 1", err_cnt - err0); end
    frame(4'hF, 340, PERIOD, -1);
    check_quiet("overlap_recover", err0 + 1);
    t0   = frame_start;
    err1 = err_cnt;
    for (int i = 0; i < 2400 && err_cnt == err1; i++) tick(4'h0, 4'h0, 1'b0);
    vectors++;
    if (err_cnt == err1) begin
      miscompares++;
      $display("FAIL timeout_missing: got no err in 2400 idle cycles, required one");
    end else begin
      lat = err_cyc - t0;
      vectors++;
      if (lat < 2174 || lat > 2180) begin
        miscompares++;
        $display("FAIL timeout_time: got err %0d cycles after last frame start, required 2174..2180", lat);
      end
    end
    vectors++;
    if (bus.locked !== 1'b0) begin miscompares++; $display("FAIL timeout_unlock: got %b, required 0", bus.locked); end
  endtask

  task automatic test_reset_decode();
    int err0;
    do_reset();
    frame(4'hF, 340, PERIOD, -1); push(5, 4'hF);
    frame(4'hF, 340, PERIOD, -1);
    tick(4'hF, 4'h0, 1'b1);
    repeat (7) tick(4'hF, 4'h0, 1'b0);
    rst = 1'b1;
    repeat (2) tick(4'h0, 4'h0, 1'b0);
    vectors++;
    if ({bus.duty_code, bus.lane_mask, bus.valid, bus.locked, bus.err} !== 11'h0) begin
      miscompares++;
      $display("FAIL decode_reset: got duty=%0d mask=%h valid=%b locked=%b err=%b, required all 0",
               bus.duty_code, bus.lane_mask, bus.valid, bus.locked, bus.err);
    end
    vectors++;
    if (sb.size() != 0) begin miscompares++; $display("FAIL decode_reset_lead: got %0d pending, required 0", sb.size()); end
    rst  = 1'b0;
    err0 = err_cnt;
    repeat (40) tick(4'h0, 4'h0, 1'b0);
    frame(4'h3, hi_for(12), PERIOD, -1); push(12, 4'h3);
    frame(4'h3, hi_for(12), PERIOD, -1);
    check_quiet("relock", err0);
    vectors++;
    if (bus.locked !== 1'b1) begin miscompares++; $display("FAIL relock_locked: got %b, required 1", bus.locked); end
  endtask

  initial begin
    bus.HSMC_RX_p = 4'h0;
    bus.HSMC_RX_n = 4'h0;
    test_reset();
    test_basic();
    test_code_sweep();
    test_lane_mask();
    test_period_err();
    test_overlap_timeout();
    test_reset_decode();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
